// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch at a time, fixed-latency
// valid/ready response, range/alignment error flagging and flush on redirect.
module imem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1,
    parameter int WIDX_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_addr,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic [63:0]       resp_addr,
    output logic              resp_error,
    input  logic              wr_en,
    input  logic [WIDX_W-1:0] wr_idx,
    input  logic [31:0]       wr_data,
    output logic              busy
);

    localparam int          WORDS = DEPTH_BYTES / 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] mem [WORDS];
    logic        accept;
    logic        err;

    assign req_ready  = (state == IDLE) && !flush && rst_n;
    assign accept     = req_valid && req_ready;
    assign err        = (req_addr >= 64'(DEPTH_BYTES)) || (req_addr[1:0] != 2'b00);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // No reset on the array: preloaded program must survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The countdown reaching zero marks the edge that enters RESP, so resp_valid
    // appears exactly LATENCY cycles after the acceptance cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        cnt_n   = 4'd0;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt_n == 4'd0) begin
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Non-blocking read of mem gives the pre-write word on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_instr <= 32'd0;
            resp_addr  <= 64'd0;
            resp_error <= 1'b0;
        end else if (accept) begin
            resp_addr  <= req_addr;
            resp_error <= err;
            resp_instr <= err ? NOP : mem[req_addr[WIDX_W+1:2]];
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=1 and a LATENCY=3 instance share stimulus;
// expected responses are queued at acceptance and compared at the handshake.
module tb_imem_responder;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_idx = 8'd0;
    logic [31:0] wr_data = 32'd0;

    logic        rdy1, val1, err1, busy1;
    logic [31:0] ins1;
    logic [63:0] adr1;
    logic        rdy3, val3, err3, busy3;
    logic [31:0] ins3;
    logic [63:0] adr3;

    int   compared = 0;
    int   mismatched = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] model [256];
    int   n;
    logic seen;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_BYTES(1024), .LATENCY(1), .WIDX_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .req_addr(req_addr), .flush(flush), .resp_valid(val1), .resp_ready(resp_ready),
        .resp_instr(ins1), .resp_addr(adr1), .resp_error(err1),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy1)
    );

    imem_responder #(.DEPTH_BYTES(1024), .LATENCY(3), .WIDX_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
        .req_addr(req_addr), .flush(flush), .resp_valid(val3), .resp_ready(resp_ready),
        .resp_instr(ins3), .resp_addr(adr3), .resp_error(err3),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t expect_for(input logic [63:0] a);
        exp_t r;
        r.addr  = a;
        r.err   = (a >= 64'd1024) || (a[1:0] != 2'b00);
        r.instr = r.err ? 32'h0000_0013 : model[a[9:2]];
        return r;
    endfunction

    task automatic load(input int idx, input logic [31:0] d);
        wr_en = 1'b1; wr_idx = 8'(idx); wr_data = d;
        step();
        wr_en = 1'b0;
        model[idx] = d;
    endtask

    task automatic wait_idle3(input string tag);
        int k;
        k = 0;
        while (!rdy3 && k < 30) begin step(); k++; end
        if (!rdy3) chk({tag, "_ready_timeout"}, 64'(rdy3), 64'd1);
    endtask

    task automatic pop_cmp3(input string tag);
        exp_t x;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            x = q.pop_front();
            chk({tag, "_instr"}, 64'(ins3), 64'(x.instr));
            chk({tag, "_addr"}, adr3, x.addr);
            chk({tag, "_err"}, 64'(err3), 64'(x.err));
        end
    endtask

    // Accept one request on the LATENCY=3 instance, check arrival time, optional stall.
    task automatic fetch3(input string tag, input logic [63:0] a, input int stall);
        wait_idle3(tag);
        resp_ready = (stall == 0);
        req_valid = 1'b1; req_addr = a;
        q.push_back(expect_for(a));
        step();
        req_valid = 1'b0;
        n = 1;
        while (!val3 && n < 20) begin step(); n++; end
        chk({tag, "_latency"}, 64'(n), 64'd3);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_hold_valid"}, 64'(val3), 64'd1);
            chk({tag, "_hold_reqrdy"}, 64'(rdy3), 64'd0);
            if (q.size() > 0) begin
                chk({tag, "_hold_instr"}, 64'(ins3), 64'(q[0].instr));
                chk({tag, "_hold_addr"}, adr3, q[0].addr);
                chk({tag, "_hold_err"}, 64'(err3), 64'(q[0].err));
            end
            step();
        end
        resp_ready = 1'b1;
        pop_cmp3(tag);
        step();
        chk({tag, "_reqrdy_after"}, 64'(rdy3), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy3), 64'd0);
    endtask

    task automatic fetch1(input string tag, input logic [63:0] a);
        int k;
        exp_t x;
        k = 0;
        while (!rdy1 && k < 10) begin step(); k++; end
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = a;
        x = expect_for(a);
        step();
        req_valid = 1'b0;
        chk({tag, "_valid_1cyc"}, 64'(val1), 64'd1);
        chk({tag, "_instr"}, 64'(ins1), 64'(x.instr));
        chk({tag, "_addr"}, adr1, x.addr);
        chk({tag, "_err"}, 64'(err1), 64'(x.err));
        step();
        chk({tag, "_idle_after"}, 64'(busy1), 64'd0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (val3) seen = 1'b1;
            step();
        end
        chk({tag, "_no_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 32'hxxxx_xxxx;
        #2;
        chk("rst_valid", 64'(val3), 64'd0);
        chk("rst_instr", 64'(ins3), 64'd0);
        chk("rst_addr", adr3, 64'd0);
        chk("rst_err", 64'(err3), 64'd0);
        chk("rst_busy", 64'(busy3), 64'd0);
        chk("rst_reqrdy", 64'(rdy3), 64'd0);
        #20 rst_n = 1'b1;
        step();

        load(0, 32'h0050_0093);
        load(1, 32'h00A0_0113);
        load(2, 32'hCAFE_0002);
        load(255, 32'hDEAD_BEEF);
        load(4, 32'h2222_2222);

        fetch1("l1_addr0", 64'h0);
        fetch1("l1_addr4", 64'h4);
        resp_ready = 1'b1;
        repeat (6) step();

        fetch3("bp_addr8", 64'h8, 5);
        fetch3("err_400", 64'h400, 0);
        fetch3("err_mis6", 64'h6, 0);
        fetch3("ok_3fc", 64'h3FC, 0);
        fetch3("err_hi", 64'h1_0000_0000, 0);

        // flush during WAIT
        wait_idle3("fl_wait");
        req_valid = 1'b1; req_addr = 64'h0;
        step();
        req_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_wait_busy", 64'(busy3), 64'd0);
        watch_quiet("fl_wait", 6);

        // flush during RESP without and with resp_ready
        for (int r = 0; r < 2; r++) begin
            wait_idle3("fl_resp");
            resp_ready = 1'b0;
            req_valid = 1'b1; req_addr = 64'h4;
            step();
            req_valid = 1'b0;
            n = 1;
            while (!val3 && n < 20) begin step(); n++; end
            chk("fl_resp_arrive", 64'(val3), 64'd1);
            flush = 1'b1; resp_ready = (r == 1);
            step();
            flush = 1'b0; resp_ready = 1'b0;
            chk("fl_resp_valid", 64'(val3), 64'd0);
            chk("fl_resp_busy", 64'(busy3), 64'd0);
            watch_quiet("fl_resp", 5);
        end
        resp_ready = 1'b1;

        // flush while idle blocks acceptance
        flush = 1'b1; req_valid = 1'b1; req_addr = 64'h0;
        #1;
        chk("fl_idle_reqrdy", 64'(rdy3), 64'd0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk("fl_idle_busy", 64'(busy3), 64'd0);

        // same-cycle write to the fetched word returns the old word
        wait_idle3("haz");
        req_valid = 1'b1; req_addr = 64'h10;
        wr_en = 1'b1; wr_idx = 8'd4; wr_data = 32'h1111_1111;
        q.push_back(expect_for(64'h10));
        model[4] = 32'h1111_1111;
        step();
        req_valid = 1'b0; wr_en = 1'b0;
        n = 1;
        while (!val3 && n < 20) begin step(); n++; end
        chk("haz_latency", 64'(n), 64'd3);
        pop_cmp3("haz_old");
        step();
        fetch3("haz_new", 64'h10, 0);

        // asynchronous reset mid-WAIT
        wait_idle3("arst");
        req_valid = 1'b1; req_addr = 64'h8;
        step();
        req_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(val3), 64'd0);
        chk("arst_busy", 64'(busy3), 64'd0);
        chk("arst_addr", adr3, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        watch_quiet("arst", 6);
        fetch3("arst_mem0", 64'h0, 0);
        fetch3("arst_mem3fc", 64'h3FC, 0);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
